// File: rtl/full_adder_using_half_adders.sv
// Ripple-carry adder built only from half-adder cells (two per bit plus an
// OR for the carry), with a combinational result and a registered,
// valid-qualified copy of the result for clocked datapaths.
// WIDTH may range from 1 to 64; WIDTH=1 is the classic 1-bit full adder.

// Half adder: sum and carry of two single-bit operands.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

module full_adder_using_half_adders #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             out_valid
);

  // ci[i] is the carry into bit i; ci[WIDTH] is the final carry-out.
  logic [WIDTH:0]   ci;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] t;

  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic             valid_d;

  assign ci[0] = c;

  // Combinational stage: one propagate/generate cell and one carry-merge
  // cell per bit; the carry ripples through every bit, no lookahead.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    half_adder u_ha1 (
      .a_i (a[i]),
      .b_i (b[i]),
      .s_o (p[i]),
      .c_o (g[i])
    );

    half_adder u_ha2 (
      .a_i (p[i]),
      .b_i (ci[i]),
      .s_o (sum[i]),
      .c_o (t[i])
    );

    assign ci[i+1] = g[i] | t[i];
  end

  assign carry = ci[WIDTH];

  // Next-state: capture the combinational result only for qualified inputs,
  // otherwise hold; the valid flag follows in_valid every cycle.
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d   = sum;
      carry_d = carry;
    end
  end

  // Register stage: one-cycle latency, cleared immediately on reset so any
  // in-flight valid data is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      out_valid <= valid_d;
    end
  end

endmodule

// File: tb/tb_full_adder_using_half_adders.sv
// Bench for full_adder_using_half_adders: WIDTH=1, 8 and 16 instances
// checked against plain-arithmetic expectations.
module tb_full_adder_using_half_adders;

  logic clk;
  logic rst_n;

  logic       a1, b1, c1, iv1;
  logic       s1, co1, sq1, cq1, ov1;

  logic [7:0] a8, b8, s8, sq8;
  logic       c8, iv8, co8, cq8, ov8;

  logic [15:0] a16, b16, s16, sq16;
  logic        c16, iv16, co16, cq16, ov16;

  int checks;
  int errors;

  full_adder_using_half_adders #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1), .in_valid(iv1),
    .sum(s1), .carry(co1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1)
  );

  full_adder_using_half_adders #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c(c8), .in_valid(iv8),
    .sum(s8), .carry(co8), .sum_q(sq8), .carry_q(cq8), .out_valid(ov8)
  );

  full_adder_using_half_adders #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c(c16), .in_valid(iv16),
    .sum(s16), .carry(co16), .sum_q(sq16), .carry_q(cq16), .out_valid(ov16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0]  tab_sum;
    logic [7:0]  tab_carry;
    logic [2:0]  v;
    logic [16:0] ref16;
    logic [15:0] mq16;
    logic        mc16;
    logic        mv16;

    checks = 0;
    errors = 0;
    tab_sum   = 8'b1001_0110;
    tab_carry = 8'b1110_1000;

    rst_n = 1'b0;
    a1 = 0; b1 = 0; c1 = 0; iv1 = 0;
    a8 = 0; b8 = 0; c8 = 0; iv8 = 0;
    a16 = 0; b16 = 0; c16 = 0; iv16 = 0;

    // Reset state, applied without any clock edge yet.
    #1;
    chk("rst_sq8", {ov8, cq8, sq8}, 10'h0);
    chk("rst_sq16", {ov16, cq16, sq16}, 18'h0);
    chk("rst_sq1", {ov1, cq1, sq1}, 3'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive truth table.
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {a1, b1, c1} = v;
      #10;
      chk($sformatf("w1_abc%0d", i), {co1, s1}, {tab_carry[i], tab_sum[i]});
    end

    // WIDTH=8 combinational boundary and pattern cases.
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; c8 = 0; #1;
    chk("w8_ripple", {co8, s8}, 9'h100);
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1; #1;
    chk("w8_ones", {co8, s8}, 9'h1FF);
    a8 = 8'h3C; b8 = 8'h0A; c8 = 1; #1;
    chk("w8_3c0a", {co8, s8}, 9'h047);
    a8 = 8'h00; b8 = 8'h00; c8 = 0; #1;
    chk("w8_zero", {co8, s8}, 9'h000);

    // Registered path: capture then hold.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; c8 = 0; iv8 = 1;
    @(posedge clk); #1;
    chk("w8_cap", {ov8, cq8, sq8}, {1'b1, 1'b1, 8'h00});
    @(negedge clk);
    iv8 = 0; a8 = 8'h12; b8 = 8'h34; c8 = 1;
    @(posedge clk); #1;
    chk("w8_hold", {ov8, cq8, sq8}, {1'b0, 1'b1, 8'h00});

    // Load 0x55, then assert reset between edges.
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h00; c8 = 0; iv8 = 1;
    @(posedge clk); #1;
    chk("w8_load55", {ov8, cq8, sq8}, {1'b1, 1'b0, 8'h55});
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("w8_async_rst", {ov8, cq8, sq8}, 10'h0);
    a8 = 8'hF0; b8 = 8'h20; c8 = 1; #1;
    chk("w8_comb_in_rst", {co8, s8}, 9'h111);

    // in_valid held through an edge during reset: data is lost.
    @(posedge clk); #1;
    chk("w8_rst_drop", {ov8, cq8, sq8}, 10'h0);

    // Release: first edge after release captures.
    @(negedge clk);
    rst_n = 1'b1;
    a8 = 8'h01; b8 = 8'h01; c8 = 1; iv8 = 1;
    @(posedge clk); #1;
    chk("w8_release", {ov8, cq8, sq8}, {1'b1, 1'b0, 8'h03});
    @(negedge clk);
    iv8 = 0;

    // WIDTH=16 randomized run against arithmetic reference.
    mq16 = '0; mc16 = 1'b0; mv16 = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      c16  = 1'($urandom);
      iv16 = ($urandom_range(0, 3) != 0);
      if (n % 97 == 0) begin
        a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
      end
      #1;
      ref16 = 17'(a16) + 17'(b16) + 17'(c16);
      chk("w16_comb", {co16, s16}, ref16);
      if (iv16) begin
        mq16 = ref16[15:0];
        mc16 = ref16[16];
      end
      mv16 = iv16;
      @(posedge clk); #1;
      chk("w16_reg", {ov16, cq16, sq16}, {mv16, mc16, mq16});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
